// File: rtl/mc_core_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset core.
// The MULTICYCLE_CORE_TRAP_EN build makes the TRAP state reachable.
package mc_core_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, TRAP
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_SUB = 7'b0100000;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
    typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_sel_e;
    typedef enum logic [1:0] {WB_ALU, WB_MDR, WB_PC} wb_sel_e;

endpackage

// File: rtl/mc_controller.sv
// FSM and instruction decode for multicycle_core.
// MULTICYCLE_CORE_TRAP_EN: illegal opcodes park the FSM in TRAP instead of retiring as NOP.
module mc_controller
    import mc_core_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic       mem_ready_i,
    input  logic       eq_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       addr_sel_o,
    output logic       ir_we_o,
    output logic       pc_we_o,
    output logic       pc_sel_o,
    output logic       ab_we_o,
    output logic       aluout_we_o,
    output logic       mdr_we_o,
    output logic       rf_we_o,
    output wb_sel_e    wb_sel_o,
    output logic       alu_a_pc_o,
    output logic       alu_b_reg_o,
    output alu_op_e    alu_op_o,
    output imm_sel_e   imm_sel_o,
    output logic       retire_o,
    output logic       halted_o
);

    state_e state_q, state_d;
    logic   req, we;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= FETCH;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (mem_ready_i) state_d = DECODE;
            DECODE: begin
                case (opcode_i)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_REG:            state_d = EXEC_R;
                    OP_IMM:            state_d = EXEC_I;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
`ifdef MULTICYCLE_CORE_TRAP_EN
                    default:           state_d = TRAP;
`else
                    default:           state_d = FETCH;
`endif
                endcase
            end
            MEMADR:   state_d = (opcode_i == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_ready_i) state_d = MEMWB;
            MEMWRITE: if (mem_ready_i) state_d = FETCH;
            EXEC_R, EXEC_I: state_d = ALUWB;
`ifdef MULTICYCLE_CORE_TRAP_EN
            TRAP:     state_d = TRAP;
`endif
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        req         = 1'b0;
        we          = 1'b0;
        addr_sel_o  = 1'b0;
        ir_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        pc_sel_o    = 1'b0;
        ab_we_o     = 1'b0;
        aluout_we_o = 1'b0;
        mdr_we_o    = 1'b0;
        rf_we_o     = 1'b0;
        wb_sel_o    = WB_ALU;
        alu_a_pc_o  = 1'b0;
        alu_b_reg_o = 1'b0;
        alu_op_o    = ALU_ADD;
        imm_sel_o   = IMM_I;
        case (state_q)
            FETCH: begin
                req     = 1'b1;
                ir_we_o = mem_ready_i;
                pc_we_o = mem_ready_i;
            end
            DECODE: begin
                // Branch/jump target is precomputed here so BRANCH and JAL take one cycle.
                ab_we_o     = 1'b1;
                aluout_we_o = 1'b1;
                alu_a_pc_o  = 1'b1;
                if (opcode_i == OP_BRANCH)   imm_sel_o = IMM_B;
                else if (opcode_i == OP_JAL) imm_sel_o = IMM_J;
            end
            MEMADR: begin
                aluout_we_o = 1'b1;
                if (opcode_i == OP_STORE) imm_sel_o = IMM_S;
            end
            MEMREAD: begin
                req        = 1'b1;
                addr_sel_o = 1'b1;
                mdr_we_o   = mem_ready_i;
            end
            MEMWB: begin
                rf_we_o  = 1'b1;
                wb_sel_o = WB_MDR;
            end
            MEMWRITE: begin
                req        = 1'b1;
                we         = 1'b1;
                addr_sel_o = 1'b1;
            end
            EXEC_R: begin
                aluout_we_o = 1'b1;
                alu_b_reg_o = 1'b1;
                case (funct3_i)
                    F3_ADD:  alu_op_o = (funct7_i == F7_SUB) ? ALU_SUB : ALU_ADD;
                    F3_SLT:  alu_op_o = ALU_SLT;
                    F3_OR:   alu_op_o = ALU_OR;
                    F3_AND:  alu_op_o = ALU_AND;
                    default: alu_op_o = ALU_ADD;
                endcase
            end
            EXEC_I: begin
                aluout_we_o = 1'b1;
                case (funct3_i)
                    F3_SLT:  alu_op_o = ALU_SLT;
                    F3_OR:   alu_op_o = ALU_OR;
                    F3_AND:  alu_op_o = ALU_AND;
                    default: alu_op_o = ALU_ADD;
                endcase
            end
            ALUWB:  rf_we_o = 1'b1;
            BRANCH: begin
                pc_sel_o = 1'b1;
                pc_we_o  = (funct3_i == F3_BNE) ? !eq_i : eq_i;
            end
            JAL: begin
                rf_we_o  = 1'b1;
                wb_sel_o = WB_PC;
                pc_we_o  = 1'b1;
                pc_sel_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Gating with reset drops the bus request immediately on an asynchronous reset.
    assign mem_req_o = req & rst_ni;
    assign mem_we_o  = we & rst_ni;
    assign retire_o  = (state_q != FETCH) && (state_d == FETCH);
`ifdef MULTICYCLE_CORE_TRAP_EN
    assign halted_o  = (state_q == TRAP);
`else
    assign halted_o  = 1'b0;
`endif

endmodule

// File: rtl/multicycle_core.sv
// Multicycle RV32I-subset core: datapath (regfile, IR, OLDPC, ALUOUT, ALU, imm extend).
// MULTICYCLE_CORE_TRAP_EN selects trap-on-illegal-opcode (see mc_controller).
module multicycle_core
    import mc_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              instr_retired,
    output logic              halted,
    output logic [31:0]       dbg_pc
);

    logic [31:0] pc_q, oldpc_q, ir_q, a_q, b_q, aluout_q, mdr_q;
    logic [31:0] rf_q [32];
    logic [31:0] imm, alu_a, alu_b, alu_y, rs1_val, rs2_val, wb_val, addr_full;
    logic [4:0]  rs1, rs2, rd;

    logic     addr_sel, ir_we, pc_we, pc_sel, ab_we, aluout_we, mdr_we, rf_we;
    logic     alu_a_pc, alu_b_reg;
    wb_sel_e  wb_sel;
    alu_op_e  alu_op;
    imm_sel_e imm_sel;

    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign rd  = ir_q[11:7];

    mc_controller u_ctrl (
        .clk_i       (clk),
        .rst_ni      (reset),
        .opcode_i    (ir_q[6:0]),
        .funct3_i    (ir_q[14:12]),
        .funct7_i    (ir_q[31:25]),
        .mem_ready_i (mem_ready),
        .eq_i        (a_q == b_q),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .addr_sel_o  (addr_sel),
        .ir_we_o     (ir_we),
        .pc_we_o     (pc_we),
        .pc_sel_o    (pc_sel),
        .ab_we_o     (ab_we),
        .aluout_we_o (aluout_we),
        .mdr_we_o    (mdr_we),
        .rf_we_o     (rf_we),
        .wb_sel_o    (wb_sel),
        .alu_a_pc_o  (alu_a_pc),
        .alu_b_reg_o (alu_b_reg),
        .alu_op_o    (alu_op),
        .imm_sel_o   (imm_sel),
        .retire_o    (instr_retired),
        .halted_o    (halted)
    );

    always_comb begin
        imm = {{20{ir_q[31]}}, ir_q[31:20]};
        case (imm_sel)
            IMM_S:   imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            IMM_B:   imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            IMM_J:   imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            default: ;
        endcase
    end

    assign alu_a = alu_a_pc  ? oldpc_q : a_q;
    assign alu_b = alu_b_reg ? b_q     : imm;

    always_comb begin
        alu_y = alu_a + alu_b;
        case (alu_op)
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
            default: ;
        endcase
    end

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

    // In JAL, pc_q already holds OLDPC+4 from the fetch, which is the link value.
    always_comb begin
        wb_val = aluout_q;
        case (wb_sel)
            WB_MDR:  wb_val = mdr_q;
            WB_PC:   wb_val = pc_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            oldpc_q  <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
        end else begin
            if (ir_we) begin
                ir_q    <= mem_rdata;
                oldpc_q <= pc_q;
            end
            if (pc_we)     pc_q     <= pc_sel ? aluout_q : pc_q + 32'd4;
            if (ab_we) begin
                a_q <= rs1_val;
                b_q <= rs2_val;
            end
            if (aluout_we) aluout_q <= alu_y;
            if (mdr_we)    mdr_q    <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (rf_we && rd != 5'd0) begin
            rf_q[rd] <= wb_val;
        end
    end

    assign addr_full = addr_sel ? aluout_q : pc_q;
    assign mem_addr  = addr_full[ADDR_W-1:0];
    assign mem_wdata = b_q;
    assign dbg_pc    = pc_q;

endmodule
